// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: FSM state encoding,
// gain code limits and default auto-ranging thresholds.
// Ports: none (package).
package acq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIAP_START,
    S_DIAP_WAIT,
    S_GAIN_EVAL,
    S_SETTLE,
    S_MEAS_START,
    S_MEAS_WAIT,
    S_STORE
  } state_t;

  localparam int GAIN_MIN  = 0;
  localparam int GAIN_MAX  = 3;

  // Width of the range-pass value examined by the auto-ranging logic.
  localparam int DIAP_BITS = 18;

  localparam logic [DIAP_BITS-1:0] HI_THR_DEF = 18'h3C000;
  localparam logic [DIAP_BITS-1:0] LO_THR_DEF = 18'h04000;

endpackage

// File: rtl/acq_sequencer_sample_strobe_gen.sv
// Free-running square-wave strobe: toggles every HALF clocks while enabled.
// Ports: clk, rst (sync, active-high), en (run the divider), strobe (output).
// When en drops the divider and strobe are cleared, so a restart is phase-aligned.
module sample_strobe_gen #(
  parameter int HALF = 312
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic strobe
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      strobe <= ~strobe;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// Measurement-cycle controller for the dual-channel ADC read engine: range pass,
// per-channel auto-ranging with analog settling, result pass, timeout supervision.
// Ports: clk/rst, run, sample_adc/start_cycle_conv/read_diapason/complete/data_in_*
// to the engine, gain_* to the front end, result_*/result_valid/busy/timeout_err to host.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 24,
  parameter int                    DIAP_WIDTH     = 2,
  parameter int                    SAMPLE_HALF    = 312,
  parameter int                    SETTLE_CYCLES  = 1024,
  parameter int                    TIMEOUT_CYCLES = 2 ** 22,
  parameter int                    CNT_WIDTH      = 22,
  parameter logic [DIAP_BITS-1:0]  HI_THR         = HI_THR_DEF,
  parameter logic [DIAP_BITS-1:0]  LO_THR         = LO_THR_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  output logic                    sample_adc,
  output logic                    start_cycle_conv,
  output logic                    read_diapason,
  input  logic                    complete,
  input  logic [DATA_WIDTH-1:0]   data_in_1,
  input  logic [DATA_WIDTH-1:0]   data_in_2,
  output logic [DIAP_WIDTH-1:0]   gain_1,
  output logic [DIAP_WIDTH-1:0]   gain_2,
  output logic [DATA_WIDTH-1:0]   result_1,
  output logic [DATA_WIDTH-1:0]   result_2,
  output logic [2*DIAP_WIDTH-1:0] result_gain,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam logic [DIAP_WIDTH-1:0] GMIN        = DIAP_WIDTH'(GAIN_MIN);
  localparam logic [DIAP_WIDTH-1:0] GMAX        = DIAP_WIDTH'(GAIN_MAX);
  localparam logic [CNT_WIDTH-1:0]  TO_LAST     = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;      // shared by settle wait and pass timeout
  logic [DIAP_BITS-1:0]   diap_1;
  logic [DIAP_BITS-1:0]   diap_2;
  logic [DIAP_WIDTH-1:0]  g1_nxt;
  logic [DIAP_WIDTH-1:0]  g2_nxt;
  logic                   run_q;
  logic                   strobe_en;

  // The strobe keeps running until the in-flight cycle has fully finished.
  assign strobe_en = run | busy;

  sample_strobe_gen #(
    .HALF (SAMPLE_HALF)
  ) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .en     (strobe_en),
    .strobe (sample_adc)
  );

  // Auto-ranging step; thresholds are strict so a value equal to either one holds.
  always_comb begin
    g1_nxt = gain_1;
    g2_nxt = gain_2;
    if (diap_1 > HI_THR && gain_1 != GMIN)      g1_nxt = gain_1 - 1'b1;
    else if (diap_1 < LO_THR && gain_1 != GMAX) g1_nxt = gain_1 + 1'b1;
    if (diap_2 > HI_THR && gain_2 != GMIN)      g2_nxt = gain_2 - 1'b1;
    else if (diap_2 < LO_THR && gain_2 != GMAX) g2_nxt = gain_2 + 1'b1;
  end

  // start_cycle_conv is raised on the transition into a START state and held
  // through the START state itself, giving exactly two cycles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      diap_1           <= '0;
      diap_2           <= '0;
      run_q            <= 1'b0;
      start_cycle_conv <= 1'b0;
      read_diapason    <= 1'b0;
      gain_1           <= '0;
      gain_2           <= '0;
      result_1         <= '0;
      result_2         <= '0;
      result_gain      <= '0;
      result_valid     <= 1'b0;
      busy             <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      run_q            <= run;
      result_valid     <= 1'b0;
      start_cycle_conv <= 1'b0;
      if (run && !run_q) timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (run) begin
            state            <= S_DIAP_START;
            busy             <= 1'b1;
            start_cycle_conv <= 1'b1;
            read_diapason    <= 1'b1;
          end
        end
        S_DIAP_START: begin
          cnt              <= '0;
          start_cycle_conv <= 1'b1;
          state            <= S_DIAP_WAIT;
        end
        S_DIAP_WAIT: begin
          if (complete) begin
            diap_1 <= data_in_1[DIAP_BITS-1:0];
            diap_2 <= data_in_2[DIAP_BITS-1:0];
            state  <= S_GAIN_EVAL;
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAIN_EVAL: begin
          gain_1 <= g1_nxt;
          gain_2 <= g2_nxt;
          cnt    <= '0;
          if (g1_nxt != gain_1 || g2_nxt != gain_2) begin
            state <= S_SETTLE;
          end else begin
            state            <= S_MEAS_START;
            start_cycle_conv <= 1'b1;
            read_diapason    <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state            <= S_MEAS_START;
            start_cycle_conv <= 1'b1;
            read_diapason    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MEAS_START: begin
          cnt              <= '0;
          start_cycle_conv <= 1'b1;
          state            <= S_MEAS_WAIT;
        end
        S_MEAS_WAIT: begin
          if (complete) begin
            state <= S_STORE;
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STORE: begin
          result_1     <= data_in_1;
          result_2     <= data_in_2;
          result_gain  <= {gain_2, gain_1};
          result_valid <= 1'b1;
          if (run) begin
            state            <= S_DIAP_START;
            start_cycle_conv <= 1'b1;
            read_diapason    <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: behavioural engine model plus a result scoreboard.
// Ports: none; drives clk/rst/run and the engine side of the DUT.
// Timeout is shortened to keep runs brief; all other parameters are defaults.
module tb_acq_sequencer;

  localparam int TB_TIMEOUT = 2000;
  localparam int ENG_LAT    = 20;
  localparam int HALF       = 312;
  localparam int SETTLE     = 1024;

  typedef struct packed {
    logic [23:0] r1;
    logic [23:0] r2;
    logic [3:0]  g;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        complete;
  logic [23:0] data_in_1, data_in_2;
  logic        sample_adc, start_cycle_conv, read_diapason, result_valid, busy, timeout_err;
  logic [1:0]  gain_1, gain_2;
  logic [23:0] result_1, result_2;
  logic [3:0]  result_gain;

  acq_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .run(run),
    .sample_adc(sample_adc), .start_cycle_conv(start_cycle_conv),
    .read_diapason(read_diapason), .complete(complete),
    .data_in_1(data_in_1), .data_in_2(data_in_2),
    .gain_1(gain_1), .gain_2(gain_2),
    .result_1(result_1), .result_2(result_2), .result_gain(result_gain),
    .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  // Engine model state and stimulus knobs
  logic [23:0] diap_v1, diap_v2, res_v1, res_v2;
  bit   eng_mute = 1'b0;
  bit   stray_req = 1'b0;
  int   m_g1 = 0, m_g2 = 0;
  int   diap_done_cyc = 0, last_gap = 0, scc_rise_cyc = 0, scc_rises = 0, diap_dones = 0;
  int   rv_count = 0, scc_w = 0;
  logic scc_q = 1'b0;
  bit   is_diap;

  // Engine: reacts to each start pulse after ENG_LAT cycles with one complete cycle.
  initial begin
    exp_t e;
    complete = 1'b0; data_in_1 = '0; data_in_2 = '0;
    forever begin
      @(posedge clk); #1;
      if (start_cycle_conv && !scc_q) begin
        is_diap = read_diapason;
        if (!is_diap) last_gap = cyc - diap_done_cyc - 1;
        scc_rise_cyc = cyc;
        scc_rises++;
        repeat (ENG_LAT) @(posedge clk);
        if (!eng_mute && !rst) begin
          @(negedge clk);
          data_in_1 = is_diap ? diap_v1 : res_v1;
          data_in_2 = is_diap ? diap_v2 : res_v2;
          complete  = 1'b1;
          if (is_diap) begin
            diap_done_cyc = cyc;
            diap_dones++;
            if (diap_v1[17:0] > 18'h3C000 && m_g1 != 0) m_g1--;
            else if (diap_v1[17:0] < 18'h04000 && m_g1 != 3) m_g1++;
            if (diap_v2[17:0] > 18'h3C000 && m_g2 != 0) m_g2--;
            else if (diap_v2[17:0] < 18'h04000 && m_g2 != 3) m_g2++;
          end else begin
            e.r1 = res_v1; e.r2 = res_v2; e.g = {2'(m_g2), 2'(m_g1)};
            exp_q.push_back(e);
            res_v1 = res_v1 + 24'd1;
          end
          @(negedge clk);
          complete = 1'b0;
        end
      end else if (stray_req) begin
        @(negedge clk); complete = 1'b1;
        @(negedge clk); complete = 1'b0;
        stray_req = 1'b0;
      end
      scc_q = start_cycle_conv;
    end
  end

  // Monitor: start pulse width and scoreboard pop on every result_valid.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (start_cycle_conv) scc_w++;
    else if (scc_w != 0) begin
      total++;
      if (scc_w != 2) begin
        bad++;
        $display("FAIL start_width: got %0d cycles, want 2", scc_w);
      end
      scc_w = 0;
    end
    if (result_valid) begin
      rv_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL result_unexpected: r1=%h r2=%h g=%b with empty scoreboard", result_1, result_2, result_gain);
      end else begin
        e = exp_q.pop_front();
        if ({result_1, result_2, result_gain} !== {e.r1, e.r2, e.g}) begin
          bad++;
          $display("FAIL result_data: got %h/%h g=%b, want %h/%h g=%b",
                   result_1, result_2, result_gain, e.r1, e.r2, e.g);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    repeat (3) @(negedge clk);
    m_g1 = 0; m_g2 = 0;
    exp_q.delete();
    rst = 1'b0;
  endtask

  // One acquisition: raise run, drop it once the range pass has started.
  task automatic run_one(output bit ok);
    int r0, s0, n;
    ok = 1'b1; s0 = scc_rises; r0 = rv_count;
    @(negedge clk) run = 1'b1;
    n = 0; while (scc_rises == s0 && n < 100) begin @(posedge clk); #1; n++; end
    @(negedge clk) run = 1'b0;
    n = 0; while (rv_count == r0 && n < 5000) begin @(posedge clk); #1; n++; end
    if (rv_count == r0) ok = 1'b0;
    n = 0; while (busy && n < 100) begin @(posedge clk); #1; n++; end
    if (busy) ok = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk) rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({sample_adc, start_cycle_conv, read_diapason, result_valid, busy, timeout_err,
         gain_1, gain_2, result_1, result_2, result_gain} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, want 0", {sample_adc, start_cycle_conv, read_diapason,
               result_valid, busy, timeout_err, gain_1, gain_2, result_1, result_2, result_gain});
    end
    do_reset();
  endtask

  task automatic test_no_settle();
    bit ok;
    int r0;
    do_reset();
    diap_v1 = 24'h20000; diap_v2 = 24'h20000; res_v1 = 24'h12345; res_v2 = 24'h0ABCD;
    r0 = rv_count;
    run_one(ok);
    total++; if (!ok) begin bad++; $display("FAIL nosettle_done: got no result, want one"); end
    total++; if (last_gap > 4) begin bad++; $display("FAIL nosettle_gap: got %0d, want <=4", last_gap); end
    total++; if (result_1 !== 24'h12345) begin bad++; $display("FAIL nosettle_r1: got %h, want 12345", result_1); end
    total++; if (result_gain !== 4'b0000) begin bad++; $display("FAIL nosettle_gain: got %b, want 0000", result_gain); end
    repeat (20) @(posedge clk); #1;
    total++; if (rv_count != r0 + 1) begin bad++; $display("FAIL nosettle_count: got %0d, want 1", rv_count - r0); end
  endtask

  task automatic test_settle();
    bit ok;
    do_reset();
    diap_v1 = 24'h01000; diap_v2 = 24'h01000; res_v1 = 24'h0AAAA; res_v2 = 24'h05555;
    run_one(ok);
    total++; if (!ok) begin bad++; $display("FAIL settle_done: got no result, want one"); end
    total++; if (last_gap != SETTLE + 1) begin bad++; $display("FAIL settle_gap: got %0d, want %0d", last_gap, SETTLE + 1); end
    total++; if (result_gain !== 4'b0101) begin bad++; $display("FAIL settle_gain: got %b, want 0101", result_gain); end
  endtask

  task automatic test_saturate();
    bit ok;
    // Step up twice more from gain 1, then hold at the ceiling.
    run_one(ok);
    run_one(ok);
    total++; if ({gain_2, gain_1} !== 4'b1111) begin bad++; $display("FAIL sat_climb: got %b, want 1111", {gain_2, gain_1}); end
    diap_v1 = 24'h00010; diap_v2 = 24'h00010;
    run_one(ok);
    total++; if (last_gap > 4) begin bad++; $display("FAIL sat_hi_gap: got %0d, want <=4", last_gap); end
    total++; if (result_gain !== 4'b1111) begin bad++; $display("FAIL sat_hi_gain: got %b, want 1111", result_gain); end
    // Floor: full-scale value from gain 0 holds.
    do_reset();
    diap_v1 = 24'h3FFFF; diap_v2 = 24'h3FFFF;
    run_one(ok);
    total++; if (last_gap > 4) begin bad++; $display("FAIL sat_lo_gap: got %0d, want <=4", last_gap); end
    total++; if (result_gain !== 4'b0000) begin bad++; $display("FAIL sat_lo_gain: got %b, want 0000", result_gain); end
    // Independent channels: ch1 held at floor, ch2 steps up.
    diap_v1 = 24'h3FFFF; diap_v2 = 24'h01000;
    run_one(ok);
    total++; if (last_gap != SETTLE + 1) begin bad++; $display("FAIL mixed_gap: got %0d, want %0d", last_gap, SETTLE + 1); end
    total++; if (result_gain !== 4'b0100) begin bad++; $display("FAIL mixed_gain: got %b, want 0100", result_gain); end
    // Values exactly on the thresholds hold the gain.
    diap_v1 = 24'h04000; diap_v2 = 24'h3C000;
    run_one(ok);
    total++; if (last_gap > 4) begin bad++; $display("FAIL thr_gap: got %0d, want <=4", last_gap); end
    total++; if (result_gain !== 4'b0100) begin bad++; $display("FAIL thr_gain: got %b, want 0100", result_gain); end
  endtask

  task automatic test_timeout();
    int s0, r0, n, gap;
    do_reset();
    eng_mute = 1'b1; s0 = scc_rises; r0 = rv_count;
    @(negedge clk) run = 1'b1;
    n = 0; while (scc_rises == s0 && n < 100) begin @(posedge clk); #1; n++; end
    @(negedge clk) run = 1'b0;
    n = 0; while (!timeout_err && n < TB_TIMEOUT + 100) begin @(posedge clk); #1; n++; end
    gap = cyc - scc_rise_cyc;
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_flag: got %b, want 1", timeout_err); end
    total++; if (gap != TB_TIMEOUT + 1) begin bad++; $display("FAIL to_time: got %0d, want %0d", gap, TB_TIMEOUT + 1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy: got %b, want 0", busy); end
    repeat (30) @(posedge clk); #1;
    total++; if (rv_count != r0) begin bad++; $display("FAIL to_noresult: got %0d results, want 0", rv_count - r0); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b, want 1", timeout_err); end
    eng_mute = 1'b0;
    diap_v1 = 24'h20000; diap_v2 = 24'h20000; res_v1 = 24'h00777; res_v2 = 24'h00888;
    @(negedge clk) run = 1'b1;
    @(posedge clk); #1;
    total++; if ({timeout_err, busy} !== 2'b01) begin bad++; $display("FAIL to_restart: got err,busy=%b, want 01", {timeout_err, busy}); end
    @(negedge clk) run = 1'b0;
    n = 0; while (rv_count == r0 && n < 500) begin @(posedge clk); #1; n++; end
    total++; if (rv_count != r0 + 1) begin bad++; $display("FAIL to_recover: got %0d results, want 1", rv_count - r0); end
  endtask

  task automatic test_run_drop_meas();
    int s0, r0, n;
    do_reset();
    diap_v1 = 24'h20000; diap_v2 = 24'h20000; res_v1 = 24'h00ABC; res_v2 = 24'h00DEF;
    s0 = scc_rises; r0 = rv_count;
    @(negedge clk) run = 1'b1;
    n = 0; while (scc_rises < s0 + 2 && n < 200) begin @(posedge clk); #1; n++; end
    @(negedge clk) run = 1'b0;
    n = 0; while ((busy || rv_count == r0) && n < 500) begin @(posedge clk); #1; n++; end
    s0 = scc_rises;
    repeat (1500) @(posedge clk); #1;
    total++; if (rv_count != r0 + 1) begin bad++; $display("FAIL drop_count: got %0d results, want 1", rv_count - r0); end
    total++; if (scc_rises != s0) begin bad++; $display("FAIL drop_nostart: got %0d extra starts, want 0", scc_rises - s0); end
    total++; if ({sample_adc, busy} !== 2'b00) begin bad++; $display("FAIL drop_idle: got sample,busy=%b, want 00", {sample_adc, busy}); end
    // A complete with no pass in flight must be ignored.
    stray_req = 1'b1;
    repeat (10) @(posedge clk); #1;
    total++; if ({busy, rv_count != r0 + 1} !== 2'b00) begin bad++; $display("FAIL stray_complete: got busy=%b results=%0d, want 0/1", busy, rv_count - r0); end
  endtask

  task automatic test_rst_in_settle();
    int d0, s0, n;
    do_reset();
    diap_v1 = 24'h01000; diap_v2 = 24'h01000;
    d0 = diap_dones;
    @(negedge clk) run = 1'b1;
    n = 0; while (diap_dones == d0 && n < 200) begin @(posedge clk); #1; n++; end
    repeat (100) @(posedge clk);
    @(negedge clk) rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({start_cycle_conv, read_diapason, result_valid, busy, timeout_err, gain_1, gain_2,
         result_1, result_2, result_gain} !== '0) begin
      bad++;
      $display("FAIL rst_settle: got busy=%b gains=%b rd=%b, want all 0", busy, {gain_2, gain_1}, read_diapason);
    end
    @(negedge clk) rst = 1'b0;
    m_g1 = 0; m_g2 = 0; exp_q.delete();
    s0 = scc_rises;
    repeat (1100) @(posedge clk); #1;
    total++; if (scc_rises != s0 || busy !== 1'b0) begin bad++; $display("FAIL rst_settle_idle: got starts=%0d busy=%b, want 0/0", scc_rises - s0, busy); end
  endtask

  task automatic test_back_to_back();
    int r0, n, t1, t2;
    logic prev;
    do_reset();
    diap_v1 = 24'h20000; diap_v2 = 24'h20000; res_v1 = 24'h00100; res_v2 = 24'h00200;
    r0 = rv_count;
    @(negedge clk) run = 1'b1;
    t1 = 0; t2 = 0;
    prev = sample_adc;
    n = 0; while (n < 1500) begin @(posedge clk); #1; n++; if (sample_adc && !prev) break; prev = sample_adc; end
    t1 = cyc; prev = sample_adc;
    n = 0; while (n < 1500) begin @(posedge clk); #1; n++; if (sample_adc && !prev) break; prev = sample_adc; end
    t2 = cyc;
    total++; if (t2 - t1 != 2 * HALF) begin bad++; $display("FAIL sample_period: got %0d, want %0d", t2 - t1, 2 * HALF); end
    n = 0; while (rv_count < r0 + 3 && n < 5000) begin @(posedge clk); #1; n++; end
    @(negedge clk) run = 1'b0;
    n = 0; while (busy && n < 500) begin @(posedge clk); #1; n++; end
    total++; if (rv_count < r0 + 3) begin bad++; $display("FAIL b2b_count: got %0d results, want >=3", rv_count - r0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d pending, want 0", exp_q.size()); end
  endtask

  initial begin
    diap_v1 = '0; diap_v2 = '0; res_v1 = '0; res_v2 = '0;
    test_reset();
    test_no_settle();
    test_settle();
    test_saturate();
    test_timeout();
    test_run_drop_meas();
    test_rst_in_settle();
    test_back_to_back();
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Measurement-cycle controller for the dual-channel ADC read engine. It generates the engine's free-running sample strobe and sequences each acquisition: a short range (diapason) pass, per-channel auto-ranging gain selection and analog settling, then a full result pass. Final results are latched together with the gain codes in force, and a timeout supervises the engine. It sits between the engine and the host/packet logic.

Parameters:
DATA_WIDTH, 24, width of engine result words
DIAP_WIDTH, 2, width of per-channel gain code (codes 0..3, 0 = lowest gain)
SAMPLE_HALF, 312, clk cycles per half-period of sample_adc
SETTLE_CYCLES, 1024, wait after any gain change before the result pass
TIMEOUT_CYCLES, 2^22, max clk cycles from a cycle start to complete
CNT_WIDTH, 22, width of shared settle/timeout counter
HI_THR, 18'h3C000, diapason value above which gain is stepped down
LO_THR, 18'h04000, diapason value below which gain is stepped up

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
run  in  1  level; 1 = continuous acquisition, 0 = stop after current cycle
sample_adc  out  1  square-wave sample strobe to engine
start_cycle_conv  out  1  cycle-start pulse to engine (engine detects the rising edge)
read_diapason  out  1  1 = range pass, 0 = result pass; held for the whole pass
complete  in  1  engine done, one clk high
data_in_1  in  DATA_WIDTH  engine channel 1 result
data_in_2  in  DATA_WIDTH  engine channel 2 result
gain_1  out  DIAP_WIDTH  channel 1 gain code to analog front end
gain_2  out  DIAP_WIDTH  channel 2 gain code
result_1  out  DATA_WIDTH  latched channel 1 result
result_2  out  DATA_WIDTH  latched channel 2 result
result_gain  out  2*DIAP_WIDTH  {gain_2,gain_1} used for the latched results
result_valid  out  1  one-cycle pulse on new results
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky; set on timeout, cleared by rst or a run rising edge

Behaviour:
- Reset values: all outputs 0, gains 0, state IDLE, sample divider 0.
- Sample divider:
  - While run=1 or state!=IDLE, sample_adc toggles every SAMPLE_HALF cycles.
  - Otherwise the divider is cleared and sample_adc is 0.
- start_cycle_conv: driven high for exactly 2 cycles on entry to DIAP_START or MEAS_START, otherwise 0.
- States:
  - IDLE: on run=1, go to DIAP_START.
  - DIAP_START: read_diapason=1, pulse start; clear the counter; go to DIAP_WAIT.
  - DIAP_WAIT: count each cycle. On complete=1, capture data_in_1/2[17:0] and go to GAIN_EVAL. If count reaches TIMEOUT_CYCLES, set timeout_err and go to IDLE.
  - GAIN_EVAL (1 cycle), per channel:
    - value>HI_THR and gain>0: gain-1.
    - value<LO_THR and gain<3: gain+1.
    - Otherwise hold. Saturate at 0 and 3.
    - If either gain changed, go to SETTLE; else go to MEAS_START.
  - SETTLE: count SETTLE_CYCLES, then go to MEAS_START.
  - MEAS_START: read_diapason=0, pulse start, clear the counter; go to MEAS_WAIT.
  - MEAS_WAIT: on complete, go to STORE. Timeout is handled as in DIAP_WAIT.
  - STORE:
    - Latch result_1/2 from data_in_1/2 and result_gain from the current gains.
    - Pulse result_valid.
    - If run=1, go to DIAP_START; else go to IDLE.
- Gain outputs change only in GAIN_EVAL, so they are stable through each result pass.
- complete is honoured only in the WAIT states; a complete arriving in any other state is ignored.
- run falling mid-cycle: the current cycle finishes through STORE.
- Timeout and complete in the same cycle: complete wins.
- rst mid-cycle: immediate return to reset values; gains return to 0.
- Counter comparisons are unsigned on CNT_WIDTH bits; no wrap is possible because the terminal count forces a state exit.

Decomposition:
- Package acq_pkg: state encoding constants, gain min/max constants (0, 3), default thresholds.
- Natural sub-module: sample_strobe_gen (divider and toggle with enable), reusable for other engines.

Test Plan:
- run=1, engine model returns diapason values 0x20000/0x20000 and results 0x12345/0x0ABCD → no SETTLE. The result pass starts within 4 cycles of the diapason complete. result_valid pulses once with result_1=0x12345, result_gain=0.
- Diapason values 0x01000 on both channels, from gains 0 → gains become 1. SETTLE lasts exactly 1024 cycles before start_cycle_conv rises. result_gain=0b0101.
- Gains at 3 with diapason value 0x00010 → gains stay 3, no SETTLE. Gains at 0 with value 0x3FFFF → gains stay 0.
- Engine never asserts complete → timeout_err=1 after TIMEOUT_CYCLES, busy=0, no result_valid. A run 0→1 clears timeout_err and restarts.
- run dropped during MEAS_WAIT → result_valid still pulses once, then IDLE. sample_adc stops low, and no further start_cycle_conv.
- rst asserted in SETTLE → next cycle all outputs 0 and state IDLE. start_cycle_conv is always exactly 2 cycles wide, with a period of 2*SAMPLE_HALF measured on sample_adc.
